// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage: boot/run/halt control, trap entry/return,
// redirects with misalignment trapping. Optional return-address stack under `PC_SEQ_RAS_EN.
//
// state  | meaning
// BOOT   | first cycle after reset, controls ignored, PC = RESET_VECTOR
// RUN    | fetching, next PC chosen by priority
// HALTED | PC frozen, only trap_i or resume_i leave
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 'h0040_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h0040_0180,
  parameter int              INSTR_BYTES  = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            halt_i,
  input  logic            resume_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_i,
  input  logic            trap_ret_i,
  input  logic            call_i,
  input  logic [XLEN-1:0] link_addr_i,
  input  logic            ret_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic [XLEN-1:0] epc_o,
  output logic            fetch_valid_o,
  output logic            misaligned_o,
  output logic            ras_empty_o
);

  localparam int OFF_W = $clog2(INSTR_BYTES);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_nxt, epc_nxt;
  logic            mis_nxt;
  logic            target_mis;
  logic            ras_hit;
  logic            ras_pop;
  logic [XLEN-1:0] ras_top;

  assign pc_plus_o     = pc_o + XLEN'(INSTR_BYTES);
  assign fetch_valid_o = (state == RUN);
  assign target_mis    = |redirect_target_i[OFF_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= BOOT;
      pc_o         <= RESET_VECTOR;
      epc_o        <= '0;
      misaligned_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc_o         <= pc_nxt;
      epc_o        <= epc_nxt;
      misaligned_o <= mis_nxt;
    end
  end

  // Halt only wins over sequential flow, stall and RAS returns; control transfers beat it.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_o;
    epc_nxt   = epc_o;
    mis_nxt   = 1'b0;
    ras_pop   = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (trap_i) begin
          pc_nxt  = TRAP_VECTOR;
          epc_nxt = pc_o;
        end else if (trap_ret_i) begin
          pc_nxt = epc_o;
        end else if (redirect_valid_i && !target_mis) begin
          pc_nxt = redirect_target_i;
        end else if (redirect_valid_i) begin
          pc_nxt  = TRAP_VECTOR;
          epc_nxt = redirect_target_i;
          mis_nxt = 1'b1;
        end else if (halt_i) begin
          state_nxt = HALTED;
        end else if (ret_i && ras_hit) begin
          pc_nxt  = ras_top;
          ras_pop = 1'b1;
        end else if (!stall_i) begin
          pc_nxt = pc_plus_o;
        end
      end
      HALTED: begin
        if (trap_i) begin
          pc_nxt    = TRAP_VECTOR;
          epc_nxt   = pc_o;
          state_nxt = RUN;
        end else if (resume_i) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

`ifdef PC_SEQ_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] sp, sp_inc, sp_dec;
  logic [CNT_W-1:0] cnt;
  logic             ras_push;

  assign ras_push    = call_i && !trap_i && (state != BOOT);
  assign sp_inc      = (sp == PTR_W'(RAS_DEPTH - 1)) ? '0 : sp + 1'b1;
  assign sp_dec      = (sp == '0) ? PTR_W'(RAS_DEPTH - 1) : sp - 1'b1;
  assign ras_hit     = (cnt != '0);
  assign ras_top     = ras_mem[sp];
  assign ras_empty_o = (cnt == '0);

  // sp points at the top entry; a full push overwrites the oldest slot by wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sp  <= '0;
      cnt <= '0;
    end else if (ras_push && !ras_pop) begin
      sp <= sp_inc;
      if (cnt != CNT_W'(RAS_DEPTH)) cnt <= cnt + 1'b1;
    end else if (ras_pop && !ras_push) begin
      sp  <= sp_dec;
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && ras_push) begin
      if (ras_pop) ras_mem[sp] <= link_addr_i;
      else         ras_mem[sp_inc] <= link_addr_i;
    end
  end
`else
  logic unused_ras;
  assign unused_ras  = ^{call_i, ret_i, link_addr_i, ras_pop};
  assign ras_hit     = 1'b0;
  assign ras_top     = '0;
  assign ras_empty_o = 1'b1;
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle/pipelined CPU fetch stage. It replaces the bare PC register: it selects the next PC from sequential increment, execute-stage redirect, trap entry and trap return. It also adds stall/halt control, a boot cycle, misaligned-target trapping, and an optional return-address stack (RAS). Output `pc_o` drives the instruction memory address directly.

## Interface
- `XLEN`, 32, PC/address width.
- `RESET_VECTOR`, 32'h0040_0000, PC value loaded on reset.
- `TRAP_VECTOR`, 32'h0040_0180, PC loaded on trap entry.
- `INSTR_BYTES`, 4, sequential increment. Must be a power of two ≥ 2.
- `RAS_DEPTH`, 4, RAS entries. Must be ≥ 2; used only when the RAS is compiled in.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `stall_i` in 1: hold the PC this cycle.
- `halt_i` in 1: enter HALTED.
- `resume_i` in 1: leave HALTED.
- `redirect_valid_i` in 1: taken branch or jump from execute.
- `redirect_target_i` in XLEN: redirect destination.
- `trap_i` in 1: exception or interrupt entry.
- `trap_ret_i` in 1: return from trap to `epc_o`.
- `call_i` in 1: push `link_addr_i` onto the RAS.
- `link_addr_i` in XLEN: return address to push.
- `ret_i` in 1: predicted return; pop the RAS and jump.
- `pc_o` out XLEN: current PC.
- `pc_plus_o` out XLEN: `pc_o + INSTR_BYTES`, combinational.
- `epc_o` out XLEN: saved exception PC.
- `fetch_valid_o` out 1: `pc_o` is a live fetch address.
- `misaligned_o` out 1: one-cycle pulse on a misaligned redirect.
- `ras_empty_o` out 1: RAS holds no entries.

## Operation
- State machine states: BOOT, RUN, HALTED.
  - BOOT → RUN unconditionally after one cycle.
  - RUN → HALTED on `halt_i`, unless a trap or redirect has higher priority in the same cycle.
  - HALTED → RUN on `resume_i` or `trap_i`.
- Reset (`rst`=0 at an edge), regardless of state or operation in progress:
  - `pc_o`=RESET_VECTOR, `epc_o`=0, state=BOOT.
  - RAS cleared, `misaligned_o`=0.
- `fetch_valid_o` is 1 only in RUN.
- Next-PC priority in RUN, highest first:
  1. `trap_i`: PC ← TRAP_VECTOR; `epc_o` ← `pc_o`.
  2. `trap_ret_i`: PC ← `epc_o`.
  3. `redirect_valid_i` with an aligned target: PC ← `redirect_target_i`.
  4. `redirect_valid_i` with a misaligned target: PC ← TRAP_VECTOR; `epc_o` ← target; `misaligned_o` ← 1 for one cycle.
  5. `ret_i` with RAS non-empty: PC ← RAS top; pop.
  6. `stall_i`: PC held.
  7. Otherwise: PC ← `pc_o + INSTR_BYTES`.
- Misaligned means `redirect_target_i[log2(INSTR_BYTES)-1:0] != 0`.
- Redirect and trap override `stall_i`, because stall only freezes sequential flow.
- In HALTED:
  - PC is held.
  - `trap_i` is honoured: vector taken and `epc_o` captured.
  - `redirect_valid_i`, `trap_ret_i` and `ret_i` are ignored.
- In BOOT, all control inputs are ignored.
- Arithmetic is modulo 2^XLEN; the PC wraps from the top of the address space to 0 with no flag.

## Timing
- Every PC source has one-cycle latency: the input sampled at edge N appears on `pc_o` after edge N.
- `pc_plus_o` has zero latency relative to `pc_o`.
- `epc_o` updates on the same edge as the trap vector load.
- After reset release, `fetch_valid_o` first rises one cycle later, with `pc_o`=RESET_VECTOR.
- When `trap_i` and `trap_ret_i` are high together, trap entry wins and `epc_o` ← `pc_o`.

## Configuration
- Macro `PC_SEQ_RAS_EN`.
- Defined: RAS of `RAS_DEPTH` entries, implemented as a circular stack with a saturating count.
  - `call_i` pushes `link_addr_i` in any state other than BOOT and in any cycle without `trap_i`.
  - A push when full overwrites the oldest entry; the count stays at RAS_DEPTH.
  - A pop happens only when `ret_i` is the selected PC source.
  - `ret_i` while empty is ignored; normal priority continues.
  - `call_i` and `ret_i` in the same selected cycle: pop the top as the target, then push `link_addr_i` (net: top replaced).
- Undefined: no RAS storage; `call_i`, `ret_i` and `link_addr_i` are ignored; `ras_empty_o` is tied to 1.

## Test plan
- Reset and boot: hold `rst`=0 for 3 cycles, then release.
  - Required: `pc_o`=0x00400000, `fetch_valid_o`=0 for one cycle, then 1.
  - Required: following values 0x00400004, 0x00400008, …
- Stall vs redirect: at PC 0x00400010, assert `stall_i` for 2 cycles.
  - Required: PC held at 0x00400010.
  - Then drive `stall_i`=1 together with redirect to 0x00400100. Required: next PC 0x00400100.
- Trap entry and return, with a misaligned redirect:
  - `trap_i` at PC 0x00400020. Required: PC 0x00400180, `epc_o`=0x00400020.
  - `trap_ret_i`. Required: PC 0x00400020.
  - Redirect to 0x00400102. Required: PC 0x00400180, `epc_o`=0x00400102, one-cycle `misaligned_o` pulse.
- Halt: assert `halt_i`, then toggle `stall_i` and redirect for 5 cycles.
  - Required: PC frozen, `fetch_valid_o`=0.
  - Assert `resume_i`. Required: sequential flow continues from the held PC.
- RAS, with `PC_SEQ_RAS_EN` defined:
  - Push 0xA0, 0xB0, 0xC0, 0xD0, 0xE0, then 5× `ret_i`.
  - Required: targets 0xE0, 0xD0, 0xC0, 0xB0.
  - Required: the 5th `ret_i` is ignored (sequential increment) and `ras_empty_o`=1.
- Wrap and mid-operation reset:
  - Redirect to 0xFFFFFFFC, then one sequential step. Required: `pc_o`=0.
  - Drop `rst` during a HALTED or trap sequence. Required: full reset values on the next edge.
